// File: rtl/joy_serial_tx.sv
// rtl/joy_serial_tx.sv - serial joystick link transmitter (parallel-in/serial-out emulation)
//
// Captures two 6-button joystick ports as a 16-bit active-low frame while the
// host load strobe is low, then shifts the frame out MSB-first, one bit per
// synchronised rising edge of the host shift clock.
//
// Optional feature macro: JOY_SERIAL_TX_DEBOUNCE_EN adds a per-button debounce
// filter of DEBOUNCE_CYCLES stable samples; without it buttons are only
// synchronised.
//
// Ports:
//   clk_i         system clock
//   res_n_i       synchronous active-low reset
//   joy_load_i    host load strobe (low = load, high = shift enabled), async
//   joy_clk_i     host shift clock, async; each rising edge shifts one bit
//   joy1_n_i      port 1 buttons {fire2, fire1, up, down, left, right}, active-low
//   joy2_n_i      port 2 buttons, same order
//   joy_data_o    serial data, registered copy of the frame MSB
//   frame_done_o  one-cycle pulse on the 16th shift
//   bit_cnt_o     bits shifted since the last load, saturating at 16

module joy_serial_tx #(
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic       joy_load_i,
    input  logic       joy_clk_i,
    input  logic [5:0] joy1_n_i,
    input  logic [5:0] joy2_n_i,
    output logic       joy_data_o,
    output logic       frame_done_o,
    output logic [4:0] bit_cnt_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t      state;
    logic        load_s1, load_s2, load_s3;
    logic        clk_s1, clk_s2, clk_s3;
    logic [11:0] btn_s1, btn_s2;
    logic [11:0] btn;
    logic [15:0] shift_reg;
    logic [15:0] frame;
    logic [4:0]  bit_cnt;
    logic        frame_done;
    logic        data;
    logic        clk_rise;

    // Host strobes: two synchroniser stages plus one edge-detect stage.
    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            load_s1 <= 1'b1;
            load_s2 <= 1'b1;
            load_s3 <= 1'b1;
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            btn_s1  <= '1;
            btn_s2  <= '1;
        end else begin
            load_s1 <= joy_load_i;
            load_s2 <= load_s1;
            load_s3 <= load_s2;
            clk_s1  <= joy_clk_i;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            btn_s1  <= {joy1_n_i, joy2_n_i};
            btn_s2  <= btn_s1;
        end
    end

    assign clk_rise = clk_s2 & ~clk_s3;

`ifdef JOY_SERIAL_TX_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [11:0]   btn_db;
    logic [CW-1:0] db_cnt [12];

    // The counter runs only while the synchronised input disagrees with the
    // accepted value; any agreeing sample restarts the stability window.
    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            btn_db <= '1;
            for (int i = 0; i < 12; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 12; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_db[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn = btn_db;
`else
    assign btn = btn_s2;
`endif

    // btn[11:6] = joy1, btn[5:0] = joy2, each {fire2, fire1, up, down, left, right}.
    assign frame = {btn[9], btn[8], btn[7], btn[6], btn[10], btn[11], 2'b11,
                    btn[3], btn[2], btn[1], btn[0], btn[4],  btn[5],  2'b11};

    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            state      <= IDLE;
            shift_reg  <= 16'hFFFF;
            bit_cnt    <= 5'd0;
            frame_done <= 1'b0;
            data       <= 1'b1;
        end else begin
            frame_done <= 1'b0;
            data       <= shift_reg[15];
            // Load low wins over any coincident clock edge.
            if (!load_s2) begin
                state     <= LOAD;
                shift_reg <= frame;
                bit_cnt   <= 5'd0;
            end else begin
                case (state)
                    IDLE: ;
                    LOAD, SHIFT: begin
                        if (state == LOAD && !load_s3) begin
                            state <= SHIFT;
                        end
                        if (clk_rise) begin
                            shift_reg <= {shift_reg[14:0], 1'b1};
                            bit_cnt   <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd15) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (clk_rise) begin
                            shift_reg <= {shift_reg[14:0], 1'b1};
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign joy_data_o   = data;
    assign frame_done_o = frame_done;
    assign bit_cnt_o    = bit_cnt;

endmodule

// File: doc/joy_serial_tx.md
# joy_serial_tx

Transmitter end of the serial joystick link: emulates the parallel-in/serial-out shift-register chain that the serial joystick reader polls through its load, clock and data lines. Two 6-button joystick ports are captured in parallel on a host load strobe and shifted out MSB-first on host clock rising edges. It sits on joystick adapter boards and in core benches, producing the `joy_data` stream that the joystick reader deserialises.

## Interface
- `DEBOUNCE_CYCLES`, default 4096: stable-sample count for button debounce; used only when debounce is compiled in.
- `clk_i`  in  1  system clock; host strobes are asynchronous to it.
- `res_n_i`  in  1  reset, synchronous, active-low.
- `joy_load_i`  in  1  host parallel-load strobe. Low loads the frame; high enables shifting.
- `joy_clk_i`  in  1  host shift clock. Each rising edge shifts one bit.
- `joy1_n_i`  in  6  port 1 buttons, active-low, ordered {fire2, fire1, up, down, left, right}.
- `joy2_n_i`  in  6  port 2 buttons, same order as port 1.
- `joy_data_o`  out  1  serial data to the host; shows the current frame MSB.
- `frame_done_o`  out  1  one-cycle pulse when the 16th shift completes.
- `bit_cnt_o`  out  5  number of bits shifted since the last load, range 0..16, saturating.

## Operation
- Frame layout, 16 bits, bit 15 is sent first:
  - bits [15:10] = joy1 {up, down, left, right, fire1, fire2}
  - bits [9:8] = 2'b11
  - bits [7:2] = joy2 {up, down, left, right, fire1, fire2}
  - bits [1:0] = 2'b11
- Every frame bit is active-low, so a pressed button reads as 0.
- `joy_load_i` and `joy_clk_i` each pass through a 2-FF synchroniser, then a third edge-detect register.
- State machine:
  - IDLE: entered at reset. Waits for synchronised load low.
  - LOAD: active while load is low. Every cycle, shift_reg is loaded with the frame from the current (debounced) buttons and bit_cnt is cleared to 0. Clock edges are ignored.
  - SHIFT: entered when load goes high. On each synchronised clk rising edge, shift_reg becomes {shift_reg[14:0], 1'b1} and bit_cnt increments.
    - When bit_cnt goes from 15 to 16, `frame_done_o` pulses and the FSM enters DONE.
  - DONE: further clk edges keep shifting in 1s. bit_cnt holds at 16 and `frame_done_o` does not pulse again.
  - From SHIFT or DONE, load low returns the FSM to LOAD.
- `joy_data_o` = shift_reg[15], registered.
- Load low takes priority over a simultaneous clk edge in the same cycle: the cycle performs a load, not a shift.
- Load falling in mid-frame, in SHIFT, aborts the frame. The FSM reloads the frame and `frame_done_o` does not pulse.
- Button changes during SHIFT or DONE do not affect the frame in flight.

## Timing
- Reset values:
  - `joy_data_o` = 1
  - `frame_done_o` = 0
  - `bit_cnt_o` = 0
  - shift_reg = 16'hFFFF
  - FSM = IDLE
  - synchronisers = 1
  - debounced buttons = all released (1)
- Reset applied mid-frame restores all reset values on the next clk_i edge.
- Load latency: load low at the pin → shift_reg holds the frame 3 clk_i cycles later. `joy_data_o` shows bit 15 one cycle after that, 4 cycles total.
- Shift latency: joy_clk rising at the pin → `joy_data_o` shows the next bit 4 clk_i cycles later. `frame_done_o` pulses in the same cycle as the 16th shift_reg update.
- Host requirements:
  - joy_clk high phase and low phase each ≥ 4 clk_i periods.
  - load low phase ≥ 4 clk_i periods.
  - data is sampled by the host ≥ 5 clk_i after a clk rise or after load release.
  - Shorter pulses may be missed, and missing them is not an error.

## Configuration
- `JOY_SERIAL_TX_DEBOUNCE_EN` defined:
  - Each of the 12 button inputs has its own 2-FF synchroniser and a per-bit counter.
  - The debounced value updates only after the raw input has been stable for `DEBOUNCE_CYCLES` consecutive clk_i cycles.
  - LOAD uses the debounced values.
- Not defined:
  - Buttons pass through a 2-FF synchroniser only.
  - The debounce counters are not instantiated.
  - `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset, then release with no host activity → `joy_data_o`=1, `bit_cnt_o`=0, `frame_done_o`=0 for 100 cycles.
- joy1_n=6'b111110 (right pressed), joy2_n=6'b011111 (fire2 pressed), load pulse, then 16 clk pulses of 8 cycles high / 8 cycles low → `joy_data_o` sampled before each rise gives 16'b1110_1111_1111_1011, and `frame_done_o` pulses once.
- After the 16 shifts, 4 extra clk pulses → `joy_data_o`=1 throughout, `bit_cnt_o` stays at 16, no second `frame_done_o`.
- Load pulse after 7 shifts → `bit_cnt_o` returns to 0, no `frame_done_o`, and `joy_data_o` shows the fresh bit 15.
- Load low and clk rising edge land in the same synchronised cycle → shift_reg equals the loaded frame and `bit_cnt_o`=0.
- With `JOY_SERIAL_TX_DEBOUNCE_EN` and DEBOUNCE_CYCLES=16, a 10-cycle glitch on joy1 up → frame bit 15 stays 1. Holding the button low for 20 cycles → the next load gives bit 15 = 0.
